// File: rtl/nes_pkg.sv
// Shared NES system definitions: DMA state encoding and memory-mapped register addresses.
package nes_pkg;

  // CPU write to this address starts a sprite DMA.
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  // PPU OAM data port; every DMA write lands here.
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // True for a CPU bus cycle that writes the DMA trigger register.
  function automatic logic is_dma_trigger(input logic [15:0] addr, input logic wr);
    return wr && (addr == DMA_REG_ADDR);
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and memory-bus-side signals of the sprite DMA controller.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic        cpu_rdy;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        dma_busy;

  // DMA controller view: sees the CPU request and memory read data, drives the bus.
  modport master (
    input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    output cpu_rdy, bus_addr, bus_d_out, bus_write, dma_busy
  );

  // System view: CPU and memory around the controller.
  modport slave (
    output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    input  cpu_rdy, bus_addr, bus_d_out, bus_write, dma_busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to $4014, halt the CPU and copy one 256-byte page to OAM ($2004)
// as alternating read/write cycles, then hand the bus back. Idle bus is a CPU pass-through.
module oam_dma
  import nes_pkg::*;
(
  input logic       clk,
  input logic       rst,
  oam_dma_if.master io
);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       cycle_odd_q, cycle_odd_d;

  // Next-state logic for the transfer sequencer and its datapath registers.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    idx_d       = idx_q;
    latch_d     = latch_q;
    // Free-running parity; reads must land on even cycles.
    cycle_odd_d = ~cycle_odd_q;

    unique case (state_q)
      IDLE: begin
        if (is_dma_trigger(io.cpu_addr, io.cpu_write)) begin
          page_d  = io.cpu_d_out;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // An odd HALT puts the next cycle on even parity; otherwise burn one more cycle.
        state_d = cycle_odd_q ? READ : ALIGN;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        latch_d = io.bus_d_in;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      page_q      <= 8'h00;
      idx_q       <= 8'h00;
      latch_q     <= 8'h00;
      cycle_odd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      idx_q       <= idx_d;
      latch_q     <= latch_d;
      cycle_odd_q <= cycle_odd_d;
    end
  end

  // Bus mux and CPU handshake, decoded from the current state only.
  always_comb begin
    io.bus_addr  = io.cpu_addr;
    io.bus_d_out = io.cpu_d_out;
    io.bus_write = 1'b0;
    io.cpu_rdy   = 1'b0;
    io.dma_busy  = 1'b1;

    unique case (state_q)
      IDLE: begin
        io.bus_write = io.cpu_write;
        io.cpu_rdy   = 1'b1;
        io.dma_busy  = 1'b0;
      end
      HALT, ALIGN: begin
        // Dummy cycles: CPU address shown, its write strobe suppressed.
      end
      READ: begin
        io.bus_addr = {page_q, idx_q};
      end
      WRITE: begin
        io.bus_addr  = OAM_DATA_ADDR;
        io.bus_d_out = latch_q;
        io.bus_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: pass-through, parity-aligned transfers, page wrap,
// mid-transfer reset and back-to-back triggers, with a scoreboard of expected OAM bytes.
module tb_oam_dma;
  import nes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic par;  // model of the DUT's cycle parity for the current cycle

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_q [$];

  oam_dma_if intf ();

  assign intf.bus_d_in = mem[intf.bus_addr];

  oam_dma dut (
    .clk (clk),
    .rst (rst),
    .io  (intf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    par = rst ? ~par : 1'b0;
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
    intf.cpu_addr  = a;
    intf.cpu_d_out = d;
    intf.cpu_write = w;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_rdy"},  intf.cpu_rdy, 1);
    chk({tag, "_busy"}, intf.dma_busy, 0);
    chk({tag, "_addr"}, intf.bus_addr, intf.cpu_addr);
    chk({tag, "_data"}, intf.bus_d_out, intf.cpu_d_out);
    chk({tag, "_wr"},   intf.bus_write, intf.cpu_write);
  endtask

  // Trigger a transfer in the current (idle) cycle and follow it to completion.
  // abort_at >= 0 pulls reset at the end of the READ with that index.
  // keep leaves the trigger write on the CPU bus in the first idle cycle afterwards.
  task automatic do_xfer(input logic [7:0] pg, input int abort_at, input bit keep);
    int   halted  = 0;
    int   reads   = 0;
    int   writes  = 0;
    int   dummies = 0;
    logic hp;
    logic [7:0] b;

    drive(DMA_REG_ADDR, pg, 1'b1);
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[{pg, 8'(i)}]);
    hp = ~par;

    @(negedge clk);
    chk("trig_rdy",  intf.cpu_rdy, 1);
    chk("trig_busy", intf.dma_busy, 0);
    chk("trig_addr", intf.bus_addr, DMA_REG_ADDR);
    chk("trig_wr",   intf.bus_write, 1);
    chk("trig_data", intf.bus_d_out, pg);
    tick();

    // CPU keeps presenting the $4014 write while halted; it must never reach the bus.
    while (intf.cpu_rdy !== 1'b1) begin
      if (halted >= 600) begin
        chk("xfer_timeout", halted, hp ? 513 : 514);
        break;
      end
      @(negedge clk);
      halted++;
      chk("busy", intf.dma_busy, 1);
      if (intf.bus_write) begin
        chk("wr_addr", intf.bus_addr, OAM_DATA_ADDR);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("wr_data", intf.bus_d_out, b);
        end else begin
          chk("wr_overrun", writes + 1, 256);
        end
        writes++;
      end else if (intf.bus_addr == DMA_REG_ADDR) begin
        dummies++;
      end else begin
        chk("rd_addr", intf.bus_addr, {pg, 8'(reads)});
        if (reads == 0) chk("rd_first_par", par, 0);
        reads++;
        if (reads - 1 == abort_at) begin
          rst = 1'b0;
          drive(16'h0300, 8'h77, 1'b1);
          tick();
          rst = 1'b1;
          return;
        end
      end
      tick();
    end

    chk("halted",  halted, hp ? 513 : 514);
    chk("dummies", dummies, hp ? 1 : 2);
    chk("reads",   reads, 256);
    chk("sb_left", exp_q.size(), 0);
    if (!keep) drive(16'h8000, 8'h00, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    rst = 1'b0;
    par = 1'b0;
    drive(16'h0000, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    chk_idle("reset");
    tick();

    // Pass-through: read then write
    drive(16'h8000, 8'h00, 1'b0);
    @(negedge clk);
    chk("pt_rd_addr", intf.bus_addr, 16'h8000);
    chk("pt_rd_wr",   intf.bus_write, 0);
    chk("pt_rd_rdy",  intf.cpu_rdy, 1);
    tick();
    drive(16'h0300, 8'h5A, 1'b1);
    @(negedge clk);
    chk("pt_wr_addr", intf.bus_addr, 16'h0300);
    chk("pt_wr_data", intf.bus_d_out, 8'h5A);
    chk("pt_wr_wr",   intf.bus_write, 1);
    chk("pt_wr_rdy",  intf.cpu_rdy, 1);
    tick();

    // HALT on odd parity
    drive(16'h8000, 8'h00, 1'b0);
    while (par != 1'b0) tick();
    do_xfer(8'h02, -1, 1'b0);
    chk_idle("post_odd");
    tick();

    // HALT on even parity
    while (par != 1'b1) tick();
    do_xfer(8'h02, -1, 1'b0);
    chk_idle("post_even");
    tick();

    // Last page: reads must stop at $FFFF
    do_xfer(8'hFF, -1, 1'b0);
    chk_idle("post_ff");
    tick();

    // Reset during READ of idx $40, then a fresh transfer from idx 0
    do_xfer(8'h03, 'h40, 1'b0);
    chk_idle("post_rst");
    chk("rst_sb_left", exp_q.size(), 192);
    exp_q.delete();
    tick();
    do_xfer(8'h03, -1, 1'b0);
    chk_idle("post_restart");
    tick();

    // Back-to-back: retrigger in the first idle cycle
    do_xfer(8'h02, -1, 1'b1);
    do_xfer(8'hFF, -1, 1'b0);
    chk_idle("post_b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
